// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage with a 2-entry skid buffer.
// in_ready and out_valid come from flops; excepting entries carry pc/inst only.
module pipe_stage_skid_reg #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned CTRL_W = 16,
   parameter int unsigned DATA_W = 256,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_except,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_npc,
   input  logic [31:0]       in_inst,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_except,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_npc,
   output logic [31:0]       out_inst,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  squash_cnt
);

   // State is {main_v, skid_v}; 2'b01 cannot be reached.
   localparam logic [1:0] S_EMPTY = 2'b00;
   localparam logic [1:0] S_ONE   = 2'b10;
   localparam logic [1:0] S_TWO   = 2'b11;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_in_ready;

   logic              w_acc;
   logic              w_pop;
   logic              w_ld_main_in;
   logic              w_ld_skid_in;
   logic              w_ld_main_skid;
   logic              w_clr_main;
   logic              w_clr_skid;
   logic [1:0]        w_sq_add;

   logic              r_m_except;
   logic [XLEN-1:0]   r_m_pc;
   logic [XLEN-1:0]   r_m_npc;
   logic [31:0]       r_m_inst;
   logic [CTRL_W-1:0] r_m_ctrl;
   logic [DATA_W-1:0] r_m_data;

   logic              r_s_except;
   logic [XLEN-1:0]   r_s_pc;
   logic [XLEN-1:0]   r_s_npc;
   logic [31:0]       r_s_inst;
   logic [CTRL_W-1:0] r_s_ctrl;
   logic [DATA_W-1:0] r_s_data;

   logic [XLEN-1:0]   w_in_npc;
   logic [CTRL_W-1:0] w_in_ctrl;
   logic [DATA_W-1:0] w_in_data;

   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_squash_cnt;

   assign w_acc = in_valid & r_in_ready;
   assign w_pop = r_state[1] & out_ready;

   // An excepting instruction must not cause side effects downstream.
   assign w_in_npc  = in_except ? '0 : in_npc;
   assign w_in_ctrl = in_except ? '0 : in_ctrl;
   assign w_in_data = in_except ? '0 : in_data;

   // Entries that were valid and not popped on a flush cycle.
   assign w_sq_add = {1'b0, r_state[1] & ~w_pop} + {1'b0, r_state[0]};

   // State register; in_ready is kept as its own flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= ~w_state_nxt[0];
      end
   end

   // Next-state logic; flush wins over any handshake.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_EMPTY;
      end else begin
         unique case (r_state)
            S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
            S_ONE: begin
               if (w_acc && !w_pop)      w_state_nxt = S_TWO;
               else if (!w_acc && w_pop) w_state_nxt = S_EMPTY;
            end
            S_TWO:   if (w_pop) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   // Datapath load/clear strobes decoded from state and handshakes.
   always_comb begin
      w_ld_main_in   = 1'b0;
      w_ld_skid_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_clr_main     = 1'b0;
      w_clr_skid     = 1'b0;
      if (flush) begin
         w_clr_main = 1'b1;
         w_clr_skid = 1'b1;
      end else begin
         unique case (r_state)
            S_EMPTY: w_ld_main_in = w_acc;
            S_ONE: begin
               if (w_acc && w_pop) w_ld_main_in = 1'b1;
               else if (w_acc)     w_ld_skid_in = 1'b1;
               else if (w_pop)     w_clr_main   = 1'b1;
            end
            S_TWO: begin
               w_ld_main_skid = w_pop;
               w_clr_skid     = w_pop;
            end
            default: begin
               w_clr_main = 1'b1;
               w_clr_skid = 1'b1;
            end
         endcase
      end
   end

   // MAIN entry: refilled from input or SKID, zeroed when it empties.
   always_ff @(posedge clk) begin
      if (rst || w_clr_main) begin
         r_m_except <= 1'b0;
         r_m_pc     <= '0;
         r_m_npc    <= '0;
         r_m_inst   <= '0;
         r_m_ctrl   <= '0;
         r_m_data   <= '0;
      end else if (w_ld_main_in) begin
         r_m_except <= in_except;
         r_m_pc     <= in_pc;
         r_m_npc    <= w_in_npc;
         r_m_inst   <= in_inst;
         r_m_ctrl   <= w_in_ctrl;
         r_m_data   <= w_in_data;
      end else if (w_ld_main_skid) begin
         r_m_except <= r_s_except;
         r_m_pc     <= r_s_pc;
         r_m_npc    <= r_s_npc;
         r_m_inst   <= r_s_inst;
         r_m_ctrl   <= r_s_ctrl;
         r_m_data   <= r_s_data;
      end
   end

   // SKID entry: holds the younger instruction under backpressure.
   always_ff @(posedge clk) begin
      if (rst || w_clr_skid) begin
         r_s_except <= 1'b0;
         r_s_pc     <= '0;
         r_s_npc    <= '0;
         r_s_inst   <= '0;
         r_s_ctrl   <= '0;
         r_s_data   <= '0;
      end else if (w_ld_skid_in) begin
         r_s_except <= in_except;
         r_s_pc     <= in_pc;
         r_s_npc    <= w_in_npc;
         r_s_inst   <= in_inst;
         r_s_ctrl   <= w_in_ctrl;
         r_s_data   <= w_in_data;
      end
   end

   // Perf counters; only rst clears them, both wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_squash_cnt <= '0;
      end else begin
         if (r_state[1] && !out_ready)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (flush)
            r_squash_cnt <= r_squash_cnt + CNT_W'(w_sq_add);
      end
   end

   assign in_ready   = r_in_ready;
   assign out_valid  = r_state[1];
   assign out_except = r_m_except;
   assign out_pc     = r_m_pc;
   assign out_npc    = r_m_npc;
   assign out_inst   = r_m_inst;
   assign out_ctrl   = r_m_ctrl;
   assign out_data   = r_m_data;
   assign stall_cnt  = r_stall_cnt;
   assign squash_cnt = r_squash_cnt;

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg (CNT_W=4 to reach counter wrap).
// Driver pushes expected entries on accept; monitor pops on each pop.
module tb_pipe_stage_skid_reg;

   localparam int XLEN   = 64;
   localparam int CTRL_W = 16;
   localparam int DATA_W = 256;
   localparam int CNT_W  = 4;

   typedef struct packed {
      logic              ex;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   npc;
      logic [31:0]       inst;
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              in_except;
   logic [XLEN-1:0]   in_pc;
   logic [XLEN-1:0]   in_npc;
   logic [31:0]       in_inst;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_except;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_npc;
   logic [31:0]       out_inst;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  squash_cnt;

   int   n_chk = 0;
   int   n_err = 0;
   ent_t q[$];

   pipe_stage_skid_reg #(
      .XLEN(XLEN), .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_except(in_except),
      .in_pc(in_pc), .in_npc(in_npc), .in_inst(in_inst),
      .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_except(out_except), .out_pc(out_pc), .out_npc(out_npc),
      .out_inst(out_inst), .out_ctrl(out_ctrl), .out_data(out_data),
      .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected stored entry: excepting writes keep only pc/inst/except.
   function automatic ent_t model_in();
      ent_t e;
      e.ex   = in_except;
      e.pc   = in_pc;
      e.inst = in_inst;
      e.npc  = in_except ? '0 : in_npc;
      e.ctrl = in_except ? '0 : in_ctrl;
      e.data = in_except ? '0 : in_data;
      return e;
   endfunction

   task automatic drive(logic v, logic ex, logic [63:0] pc);
      in_valid  = v;
      in_except = ex;
      in_pc     = pc;
      in_npc    = pc + 64'd4;
      in_inst   = pc[31:0] ^ 32'h13;
      in_ctrl   = pc[15:0] | 16'h1;
      in_data   = {4{pc}};
   endtask

   // One clock: record accepts, and drop squashed entries after flush/rst.
   task automatic cycle();
      logic kill;
      @(negedge clk);
      kill = flush | rst;
      if (!kill && in_valid && in_ready) q.push_back(model_in());
      @(posedge clk);
      #1;
      if (kill) q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 64'h0);
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   // Monitor: every pop must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         ent_t a;
         ent_t e;
         a = '{out_except, out_pc, out_npc, out_inst, out_ctrl, out_data};
         n_chk++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got pc %h expected none", out_pc);
         end else begin
            e = q.pop_front();
            if (a !== e) begin
               n_err++;
               $display("FAIL pop_entry: got %h expected %h", a, e);
            end
         end
      end
   end

   initial begin
      do_reset();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_pc", out_pc, 64'h0);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      chk("rst_squash", 64'(squash_cnt), 64'd0);

      // 1. streaming
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 64'h1000 + 64'(4 * i));
         cycle();
         chk("t1_out_pc", out_pc, 64'h1000 + 64'(4 * i));
         chk("t1_in_ready", 64'(in_ready), 64'd1);
      end
      drive(1'b0, 1'b0, 64'h0);
      cycle();
      chk("t1_empty", 64'(out_valid), 64'd0);
      chk("t1_stall", 64'(stall_cnt), 64'd0);

      // 2. backpressure into SKID, then drain A, B, C
      do_reset();
      drive(1'b1, 1'b0, 64'h2000);
      cycle();
      drive(1'b1, 1'b0, 64'h2004);
      cycle();
      chk("t2_two_in_ready", 64'(in_ready), 64'd0);
      chk("t2_stall1", 64'(stall_cnt), 64'd1);
      drive(1'b1, 1'b0, 64'h2008);
      cycle();
      chk("t2_hold_pc", out_pc, 64'h2000);
      chk("t2_hold_ready", 64'(in_ready), 64'd0);
      chk("t2_stall2", 64'(stall_cnt), 64'd2);
      out_ready = 1'b1;
      cycle();
      chk("t2_b_head", out_pc, 64'h2004);
      chk("t2_ready_back", 64'(in_ready), 64'd1);
      cycle();
      chk("t2_c_head", out_pc, 64'h2008);
      drive(1'b0, 1'b0, 64'h0);
      cycle();
      chk("t2_drained", 64'(out_valid), 64'd0);
      chk("t2_stall_end", 64'(stall_cnt), 64'd2);
      chk("t2_queue", 64'(q.size()), 64'd0);

      // 3. exception squash
      do_reset();
      in_valid = 1'b1;
      in_except = 1'b1;
      in_pc = 64'h3000;
      in_npc = 64'h3004;
      in_inst = 32'h00000073;
      in_ctrl = '1;
      in_data = '1;
      cycle();
      chk("t3_except", 64'(out_except), 64'd1);
      chk("t3_pc", out_pc, 64'h3000);
      chk("t3_inst", 64'(out_inst), 64'h73);
      chk("t3_ctrl", 64'(out_ctrl), 64'd0);
      chk("t3_data_or", 64'(|out_data), 64'd0);
      chk("t3_npc", out_npc, 64'h0);
      drive(1'b0, 1'b0, 64'h0);
      out_ready = 1'b1;
      cycle();
      chk("t3_clr_pc", out_pc, 64'h0);
      chk("t3_clr_ex", 64'(out_except), 64'd0);

      // 4. flush in TWO with accept attempt, then in ONE with pop
      do_reset();
      drive(1'b1, 1'b0, 64'h4000);
      cycle();
      drive(1'b1, 1'b0, 64'h4004);
      cycle();
      drive(1'b1, 1'b0, 64'h4008);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      drive(1'b0, 1'b0, 64'h0);
      chk("t4_valid", 64'(out_valid), 64'd0);
      chk("t4_pc", out_pc, 64'h0);
      chk("t4_inst", 64'(out_inst), 64'h0);
      chk("t4_in_ready", 64'(in_ready), 64'd1);
      chk("t4_squash2", 64'(squash_cnt), 64'd2);
      chk("t4_stall", 64'(stall_cnt), 64'd2);
      out_ready = 1'b1;
      drive(1'b1, 1'b0, 64'h4100);
      cycle();
      drive(1'b0, 1'b0, 64'h0);
      flush = 1'b1;
      cycle();
      chk("t4_pop_squash", 64'(squash_cnt), 64'd2);
      chk("t4_pop_valid", 64'(out_valid), 64'd0);
      drive(1'b1, 1'b0, 64'h4200);
      cycle();
      flush = 1'b0;
      drive(1'b0, 1'b0, 64'h0);
      chk("t4_acc_dropped", 64'(out_valid), 64'd0);
      chk("t4_empty_squash", 64'(squash_cnt), 64'd2);

      // 5. reset in TWO with in_valid high
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 64'h5000);
      cycle();
      drive(1'b1, 1'b0, 64'h5004);
      cycle();
      flush = 1'b1;
      drive(1'b1, 1'b0, 64'h5008);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      flush = 1'b0;
      drive(1'b0, 1'b0, 64'h0);
      chk("t5_valid", 64'(out_valid), 64'd0);
      chk("t5_in_ready", 64'(in_ready), 64'd1);
      chk("t5_stall", 64'(stall_cnt), 64'd0);
      chk("t5_squash", 64'(squash_cnt), 64'd0);
      chk("t5_pc", out_pc, 64'h0);

      // 6. stall counter wraps at 16
      drive(1'b1, 1'b0, 64'h6000);
      cycle();
      drive(1'b0, 1'b0, 64'h0);
      for (int i = 0; i < 17; i++) cycle();
      chk("t6_wrap", 64'(stall_cnt), 64'd1);
      out_ready = 1'b1;
      cycle();
      chk("t6_drain", 64'(out_valid), 64'd0);
      chk("end_queue", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
